// File: rtl/matmul_pkg.sv
// Shared definitions for the systolic matrix multiplier.
//   state_e    : controller states (IDLE, LOAD, DRAIN, DONE)
//   DEF_*      : default array dimension, operand and accumulator widths
//   cnt_width  : smallest counter width that can hold values 0..n-1 (at least 1)
//   c_idx      : slice index of C[i][j] inside the flattened result bus
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_N  = 4;
  localparam int DEF_DW = 8;
  localparam int DEF_AW = 2 * DEF_DW + $clog2(DEF_N);

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int c_idx(input int i, input int j, input int n);
    return i * n + j;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary processing element.
//   clk, reset : clock, asynchronous active-low reset
//   en         : advance (MAC into acc, capture a_in/b_in into pass registers)
//   clr        : synchronous clear of acc and pass registers (wins over en)
//   a_in, b_in : operands from the left / from above
//   a_out      : registered a, to the right neighbour
//   b_out      : registered b, to the neighbour below
//   acc        : running sum of products, wraps modulo 2^AW
module systolic_pe #(
  parameter int DW     = 8,
  parameter int AW     = 18,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [AW-1:0] acc
);

  // Product is formed at full 2*DW precision, then extended (sign or zero)
  // to at least AW bits so the accumulation wraps exactly modulo 2^AW.
  localparam int PW = (AW > 2 * DW) ? AW : 2 * DW;

  logic [DW-1:0]          a_q, a_d, b_q, b_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic signed [2*DW-1:0] prod_s;
  logic [2*DW-1:0]        prod_u;
  logic [PW-1:0]          prod_ext;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    prod_s = (2*DW)'($signed(a_in)) * (2*DW)'($signed(b_in));
    prod_u = (2*DW)'(a_in) * (2*DW)'(b_in);
    if (SIGNED != 0) prod_ext = PW'(prod_s);
    else             prod_ext = PW'(prod_u);

    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod_ext[AW-1:0];
      a_d   = a_in;
      b_d   = b_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the accumulators are
  // reset because a reset must abort a job without leaving residue for the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/param_systolic_matmul.sv
// N x N output-stationary systolic matrix multiplier, C = A x B.
//   clk, reset      : clock, asynchronous active-low reset
//   in_valid/ready  : one unskewed beat per k: a_col = column k of A, b_row = row k of B
//   a_col[i*DW+:DW] : A[i][k]        b_row[j*DW+:DW] : B[k][j]
//   out_valid/ready : c_flat holds the finished result until taken
//   c_flat          : C[i][j] at slice (i*N+j)*AW, zero outside DONE
//   busy            : controller is not IDLE
// Row i of A and column j of B get i / j enabled delay stages so that PE(i,j)
// performs its k-th MAC on enabled edge e_k+i+j. The array only advances on
// accepted beats, then runs 2N-2 free edges with zeros injected to drain.
module param_systolic_matmul
  import matmul_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DW     = DEF_DW,
  parameter int AW     = 2 * DW + $clog2(N),
  parameter int SIGNED = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] a_col,
  input  logic [N*DW-1:0] b_row,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*N*AW-1:0] c_flat,
  output logic            busy
);

  localparam int            CW        = cnt_width(2 * N);
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);
  localparam logic [CW-1:0] DRAIN_LEN = CW'(2 * N - 2);

  state_e        state_q, state_d;
  logic [CW-1:0] beat_q, beat_d, drain_q, drain_d;
  logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
  logic          accept, en, clr;

  // ---------------- controller ----------------
  always_comb begin
    accept  = in_valid && in_ready_q;
    state_d = state_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (N == 1) begin
              state_d = DONE;
            end else begin
              state_d = DRAIN;
              drain_d = DRAIN_LEN;
            end
          end else begin
            beat_d  = beat_q + CW'(1);
            state_d = LOAD;
          end
        end
      end
      DRAIN: begin
        drain_d = drain_q - CW'(1);
        if (drain_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered from the next state; holding in_ready
    // in its flop keeps it low for as long as reset is asserted.
    in_ready_d  = (state_d == IDLE) || (state_d == LOAD);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      drain_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      drain_q     <= drain_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

  // Array steps on accepted beats and on every drain edge; results are
  // cleared on the edge the consumer takes them.
  assign en  = accept || (state_q == DRAIN);
  assign clr = out_valid_q && out_ready;

  // ---------------- input skew ----------------
  logic [DW-1:0] a_src  [N];
  logic [DW-1:0] b_src  [N];
  logic [DW-1:0] a_edge [N];
  logic [DW-1:0] b_edge [N];

  for (genvar i = 0; i < N; i++) begin : g_lane
    // Zeros enter the array whenever no beat is accepted (i.e. while draining).
    assign a_src[i] = accept ? a_col[i*DW +: DW] : '0;
    assign b_src[i] = accept ? b_row[i*DW +: DW] : '0;

    if (i == 0) begin : g_direct
      assign a_edge[i] = a_src[i];
      assign b_edge[i] = b_src[i];
    end else begin : g_delay
      logic [DW-1:0] a_sr_q [i];
      logic [DW-1:0] a_sr_d [i];
      logic [DW-1:0] b_sr_q [i];
      logic [DW-1:0] b_sr_d [i];

      always_comb begin
        a_sr_d = a_sr_q;
        b_sr_d = b_sr_q;
        if (clr) begin
          a_sr_d = '{default: '0};
          b_sr_d = '{default: '0};
        end else if (en) begin
          a_sr_d[0] = a_src[i];
          b_sr_d[0] = b_src[i];
          for (int m = 1; m < i; m++) begin
            a_sr_d[m] = a_sr_q[m-1];
            b_sr_d[m] = b_sr_q[m-1];
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          a_sr_q <= '{default: '0};
          b_sr_q <= '{default: '0};
        end else begin
          a_sr_q <= a_sr_d;
          b_sr_q <= b_sr_d;
        end
      end

      assign a_edge[i] = a_sr_q[i-1];
      assign b_edge[i] = b_sr_q[i-1];
    end
  end

  // ---------------- PE grid ----------------
  logic [DW-1:0] a_pass [N][N];
  logic [DW-1:0] b_pass [N][N];
  logic [AW-1:0] acc    [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] a_in_w, b_in_w;

      if (j == 0) begin : g_a_edge
        assign a_in_w = a_edge[i];
      end else begin : g_a_pass
        assign a_in_w = a_pass[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_in_w = b_edge[j];
      end else begin : g_b_pass
        assign b_in_w = b_pass[i-1][j];
      end

      systolic_pe #(
        .DW     (DW),
        .AW     (AW),
        .SIGNED (SIGNED)
      ) u_pe (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (clr),
        .a_in  (a_in_w),
        .b_in  (b_in_w),
        .a_out (a_pass[i][j]),
        .b_out (b_pass[i][j]),
        .acc   (acc[i][j])
      );

      assign c_flat[c_idx(i, j, N)*AW +: AW] = out_valid_q ? acc[i][j] : '0;
    end
  end

endmodule

// File: tb/tb_param_systolic_matmul.sv
// Self-checking bench for param_systolic_matmul. Four builds share one
// stimulus bus; sel routes in_valid/out_ready to one build and selects which
// build's outputs are observed:
//   0: N=2, AW=17 unsigned   1: N=4, AW=18 unsigned
//   2: N=4, AW=17 unsigned   3: N=4, AW=18 signed
// Expected results come from plain matrix arithmetic reduced modulo 2^AW.
module tb_param_systolic_matmul;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic [31:0] a_col_all, b_row_all;
  int          sel;

  logic iv [4];
  logic orr [4];
  logic ir [4];
  logic ov [4];
  logic bz [4];

  logic [2*2*17-1:0] c0;
  logic [4*4*18-1:0] c1;
  logic [4*4*17-1:0] c2;
  logic [4*4*18-1:0] c3;

  always #5 clk = ~clk;

  always_comb begin
    for (int s = 0; s < 4; s++) begin
      iv[s]  = in_valid  && (sel == s);
      orr[s] = out_ready && (sel == s);
    end
  end

  param_systolic_matmul #(.N(2), .DW(8), .AW(17), .SIGNED(0)) u_n2 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
    .a_col(a_col_all[15:0]), .b_row(b_row_all[15:0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .c_flat(c0), .busy(bz[0]));

  param_systolic_matmul #(.N(4), .DW(8), .AW(18), .SIGNED(0)) u_n4 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
    .a_col(a_col_all), .b_row(b_row_all),
    .out_valid(ov[1]), .out_ready(orr[1]), .c_flat(c1), .busy(bz[1]));

  param_systolic_matmul #(.N(4), .DW(8), .AW(17), .SIGNED(0)) u_w17 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
    .a_col(a_col_all), .b_row(b_row_all),
    .out_valid(ov[2]), .out_ready(orr[2]), .c_flat(c2), .busy(bz[2]));

  param_systolic_matmul #(.N(4), .DW(8), .AW(18), .SIGNED(1)) u_sgn (
    .clk(clk), .reset(reset), .in_valid(iv[3]), .in_ready(ir[3]),
    .a_col(a_col_all), .b_row(b_row_all),
    .out_valid(ov[3]), .out_ready(orr[3]), .c_flat(c3), .busy(bz[3]));

  // Observed view of the selected build, results as integers.
  logic   cur_ir, cur_ov, cur_bz;
  longint c_cur [4][4];

  always_comb begin
    cur_ir = 1'b0;
    cur_ov = 1'b0;
    cur_bz = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) c_cur[i][j] = 0;
    case (sel)
      0: begin
        cur_ir = ir[0]; cur_ov = ov[0]; cur_bz = bz[0];
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++) c_cur[i][j] = longint'(c0[(i*2+j)*17 +: 17]);
      end
      1: begin
        cur_ir = ir[1]; cur_ov = ov[1]; cur_bz = bz[1];
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) c_cur[i][j] = longint'(c1[(i*4+j)*18 +: 18]);
      end
      2: begin
        cur_ir = ir[2]; cur_ov = ov[2]; cur_bz = bz[2];
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) c_cur[i][j] = longint'(c2[(i*4+j)*17 +: 17]);
      end
      default: begin
        cur_ir = ir[3]; cur_ov = ov[3]; cur_bz = bz[3];
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) c_cur[i][j] = longint'($signed(c3[(i*4+j)*18 +: 18]));
      end
    endcase
  end

  // ---------------- model and checking ----------------
  int     ma [4][4];
  int     mb [4][4];
  longint exp_c [4][4];
  int     n_cmp  = 0;
  int     n_fail = 0;
  bit     mon_on = 1'b0;

  task automatic check(input string name, input longint got, input longint want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // C = A x B over the first n indices, reduced to the build's AW bits.
  task automatic model_job(input int s, input int n);
    int     aw;
    longint m, v;
    aw = (s == 0 || s == 2) ? 17 : 18;
    m  = longint'(1) << aw;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        v = 0;
        if (i < n && j < n)
          for (int k = 0; k < n; k++) v += longint'(ma[i][k]) * longint'(mb[k][j]);
        v = v & (m - 1);
        if (s == 3 && v >= m / 2) v -= m;
        exp_c[i][j] = v;
      end
    end
  endtask

  // Every cycle: full matrix in DONE, all-zero c_flat otherwise.
  always @(negedge clk) begin : monitor
    int     bi, bj;
    bit     found;
    longint want;
    if (reset === 1'b1 && mon_on) begin
      bi = 0; bj = 0; found = 1'b0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          want = cur_ov ? exp_c[i][j] : 0;
          if (!found && c_cur[i][j] !== want) begin
            found = 1'b1; bi = i; bj = j;
          end
        end
      if (cur_ov) check($sformatf("result C[%0d][%0d]", bi, bj), c_cur[bi][bj], exp_c[bi][bj]);
      else        check($sformatf("c_flat zero outside DONE C[%0d][%0d]", bi, bj), c_cur[bi][bj], 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_mats();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
      end
  endtask

  task automatic load_test1();
    clear_mats();
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
  endtask

  task automatic load_test2();
    clear_mats();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = i * 4 + j + 1;
      end
  endtask

  task automatic load_fill(input int av, input int bv);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = av;
        mb[i][j] = bv;
      end
  endtask

  task automatic pack(input int n, input int k);
    a_col_all = '0;
    b_row_all = '0;
    for (int i = 0; i < n; i++) begin
      a_col_all[i*8 +: 8] = 8'(ma[i][k]);
      b_row_all[i*8 +: 8] = 8'(mb[k][i]);
    end
  endtask

  // Sends the n beats of a job; gap idle cycles follow the first beat.
  // Returns at #1 after the edge that accepted the last beat.
  task automatic send_beats(input int s, input int n, input int gap);
    int w;
    sel = s;
    model_job(s, n);
    #1;
    check("busy low before job", cur_bz, 0);
    for (int k = 0; k < n; k++) begin
      pack(n, k);
      in_valid = 1'b1;
      w = 0;
      while (!cur_ir && w < 20) begin
        @(posedge clk); #1; w++;
      end
      check($sformatf("in_ready for beat %0d", k), cur_ir, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (k == 0) check("busy after first beat", cur_bz, 1);
      if (k == 0 && gap > 0) repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_result(input int n, input bit chk_lat);
    int e;
    e = 0;
    while (!cur_ov && e < 40) begin
      @(posedge clk); #1; e++;
    end
    check("out_valid rises", cur_ov, 1);
    if (chk_lat) check("edges from last beat to out_valid", e, 2 * n - 2);
    check("busy in DONE", cur_bz, 1);
    check("in_ready low in DONE", cur_ir, 0);
  endtask

  task automatic take_result(input int hold);
    out_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      check("out_valid held under backpressure", cur_ov, 1);
      check("in_ready low during hold", cur_ir, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid drops after take", cur_ov, 0);
    check("busy drops after take", cur_bz, 0);
    check("in_ready high in IDLE", cur_ir, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_col_all = '0;
    b_row_all = '0;
    sel       = 1;
    clear_mats();
    model_job(1, 4);
    #12;
    check("reset out_valid", cur_ov, 0);
    check("reset busy", cur_bz, 0);
    check("reset in_ready", cur_ir, 0);
    check("reset c_flat C[0][0]", c_cur[0][0], 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    mon_on = 1'b1;

    // Test 1: N=2 worked example.
    load_test1();
    send_beats(0, 2, 0);
    wait_result(2, 1'b1);
    check("t1 C00", c_cur[0][0], 19);
    check("t1 C01", c_cur[0][1], 22);
    check("t1 C10", c_cur[1][0], 43);
    check("t1 C11", c_cur[1][1], 50);
    take_result(0);

    // Test 2: identity x B = B.
    load_test2();
    send_beats(1, 4, 0);
    wait_result(4, 1'b1);
    check("t2 C00", c_cur[0][0], 1);
    check("t2 C23", c_cur[2][3], 12);
    check("t2 C30", c_cur[3][0], 13);
    take_result(0);

    // Test 3: all 255, unsigned, AW=18 then AW=17.
    load_fill(255, 255);
    send_beats(1, 4, 0);
    wait_result(4, 1'b1);
    check("t3 AW18 C12", c_cur[1][2], 260100);
    take_result(0);
    send_beats(2, 4, 0);
    wait_result(4, 1'b1);
    check("t3 AW17 C33", c_cur[3][3], 129028);
    take_result(1);

    // Test 4: signed operands.
    load_fill(-128, -128);
    send_beats(3, 4, 0);
    wait_result(4, 1'b1);
    check("t4 -128 C21", c_cur[2][1], 65536);
    take_result(0);
    load_fill(0, 3);
    for (int k = 0; k < 4; k++) begin
      ma[0][k] = -1;
      ma[1][k] = 1;
      ma[2][k] = -128;
      ma[3][k] = 127;
    end
    send_beats(3, 4, 0);
    wait_result(4, 1'b1);
    check("t4 row -1 C02", c_cur[0][2], -12);
    check("t4 row -128 C20", c_cur[2][0], -1536);
    check("t4 row 127 C31", c_cur[3][1], 1524);
    take_result(0);

    // Test 5: input stall after first beat and output backpressure.
    load_test2();
    send_beats(1, 4, 3);
    wait_result(4, 1'b1);
    take_result(5);

    // Test 6: reset during drain, then fresh jobs with no residue.
    load_test2();
    send_beats(1, 4, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort out_valid", cur_ov, 0);
    check("abort busy", cur_bz, 0);
    check("abort in_ready", cur_ir, 0);
    check("abort c_flat C33", c_cur[3][3], 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    load_test1();
    send_beats(0, 2, 0);
    wait_result(2, 1'b1);
    check("t6 n2 C11", c_cur[1][1], 50);
    take_result(0);
    send_beats(1, 4, 0);
    wait_result(4, 1'b1);
    check("t6 n4 C10", c_cur[1][0], 43);
    check("t6 n4 C33", c_cur[3][3], 0);
    take_result(0);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/param_systolic_matmul.md
Name: param_systolic_matmul

Overview:
Parametrised N x N output-stationary systolic matrix multiplier, computing C = A x B for N x N operand matrices. It takes one unskewed beat per k index (column k of A, row k of B) through a valid/ready handshake and generates the diagonal input skew internally. Once the array drains, it holds the full result matrix under an output valid/ready handshake. It sits between the operand stream source and the result consumer in the matrix-acceleration datapath.

Parameters:
N, 4, array dimension and number of k beats per job (N >= 1)
DW, 8, operand width
AW, 18, accumulator/result width (default 2*DW + clog2(N)); wider sums wrap modulo 2^AW
SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands and results

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  beat on a_col/b_row is valid
in_ready  out  1  block accepts a beat
a_col  in  N*DW  a_col[i*DW +: DW] = A[i][k]
b_row  in  N*DW  b_row[j*DW +: DW] = B[k][j]
out_valid  out  1  c_flat holds the completed result
out_ready  in  1  consumer takes the result
c_flat  out  N*N*AW  c_flat[(i*N+j)*AW +: AW] = C[i][j]
busy  out  1  high when state != IDLE

Behaviour:
- Reset (reset=0, async): state IDLE; all accumulators, pass registers and skew registers cleared; beat counter 0; in_ready=0 while reset is asserted; out_valid=0; c_flat=0; busy=0. Reset mid-operation aborts the job with no partial output.
- States: IDLE, LOAD, DRAIN, DONE.
- in_ready = 1 in IDLE and LOAD, 0 in DRAIN and DONE.
- A beat is accepted on a rising edge with in_valid && in_ready.
- Beat acceptance:
  - IDLE: the first accepted beat moves the block to LOAD (to DONE if N=1 and this is the last beat).
  - The beat counter increments per accepted beat.
  - On the edge accepting beat N-1: go to DRAIN with drain counter = 2N-2, or to DONE directly when N=1.
- Array enable:
  - In IDLE/LOAD, the array and skew registers advance only on edges that accept a beat. in_valid low stalls everything, and the result is independent of gaps.
  - In DRAIN the array advances every edge with zeros injected.
- Skew: row i of A is delayed by i enabled stages; column j of B is delayed by j enabled stages. Rows/columns with index 0 feed directly.
- PE(i,j): on each enabled edge, acc += a_in*b_in (signed or unsigned per SIGNED, truncated to AW), then a passes right and b passes down through registers. PE(i,j) performs its k-th MAC on enabled edge e_k+i+j.
- DRAIN: decrement the counter each edge; on the edge the counter reaches 0 (2N-2 edges after the last-beat edge), go to DONE.
- Latency: out_valid is first high in the cycle after the (2N-2)th edge following the last-beat edge (N=4: 6 edges) when no stalls occur.
- DONE:
  - out_valid=1; c_flat mirrors the accumulators and is stable while out_valid && !out_ready.
  - On out_valid && out_ready: clear all accumulators/skew/pass registers, go to IDLE; out_valid drops next cycle.
  - No new beat is accepted in the same cycle, because in_ready=0 in DONE.
- Outside DONE, c_flat is 0.
- Overflow: sums exceeding AW bits wrap silently; no saturation, no flag.

Decomposition:
- Package matmul_pkg:
  - state enum (IDLE, LOAD, DRAIN, DONE)
  - default N/DW/AW constants
  - clog2-based counter width helper
  - index helper for the c_flat slice.
- One sub-module systolic_pe (params DW, AW, SIGNED; ports clk, reset, en, clr, a_in, b_in, a_out, b_out, acc), instantiated N*N times with generate.
- The skew delay lines and FSM stay in the top level.

Test Plan:
1. N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]]; beats (a_col=(1,3), b_row=(5,6)), (a_col=(2,4), b_row=(7,8)) back-to-back -> C=[[19,22],[43,50]]; out_valid first high the cycle after 2 edges past the last beat.
2. N=4 default, A=identity, B rows {1..4},{5..8},{9..12},{13..16} -> C=B exactly; busy high from the first beat until the result is taken.
3. N=4, all operands 255, unsigned -> every C[i][j]=260100 (fits AW=18). Same test with AW=17 -> every C[i][j]=260100 mod 131072 = 129028.
4. SIGNED=1, N=4, all operands -128 -> every C[i][j]=65536. Also A=[[-1,...]] row vs B all 3 -> C row = -12 (two's complement, AW bits).
5. Stall/backpressure: in_valid low 3 cycles between beats 1 and 2, and out_ready held low 5 cycles in DONE -> result identical to test 2; c_flat stable and in_ready=0 during the hold; IDLE one cycle after out_ready=1.
6. reset pulsed low during DRAIN of test 2 -> out_valid/busy/c_flat go 0 immediately. A following fresh job (test 1 data, N=2 build) yields the correct result with no residue.
